// File: rtl/score_display_scan.sv
// Three-digit multiplexed common-anode seven-segment scanner.
// Captures BCD score digits on a load strobe, scans one digit per refresh
// slot with a blank cycle at the start of each slot, suppresses leading
// zeros and blinks the whole display while game over is asserted.

`ifndef SCORE_DIGIT_SIZE
`define SCORE_DIGIT_SIZE 4
`endif

module score_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [`SCORE_DIGIT_SIZE-1:0] hundreds,
  input  logic [`SCORE_DIGIT_SIZE-1:0] tens,
  input  logic [`SCORE_DIGIT_SIZE-1:0] ones,
  input  logic                         score_load,
  input  logic                         game_over,
  output logic [2:0]                   an,
  output logic [6:0]                   seg,
  output logic                         frame_tick
);

  localparam int DW = `SCORE_DIGIT_SIZE;
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [2:0] AN_OFF  = 3'b111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ONES     = 2'd0,
    TENS     = 2'd1,
    HUNDREDS = 2'd2
  } digit_sel_t;

  logic [CW-1:0] cnt;
  digit_sel_t    idx;
  logic [DW-1:0] snap_h, snap_t, snap_o;
  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  logic wrap;
  logic frame_end;

  assign wrap      = (cnt == CNT_LAST);
  assign frame_end = wrap && (idx == HUNDREDS);

  // Active-low gfedcba pattern; anything outside 0..9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [DW-1:0] d);
    logic [6:0] s;
    case (d)
      DW'(0):  s = 7'h40;
      DW'(1):  s = 7'h79;
      DW'(2):  s = 7'h24;
      DW'(3):  s = 7'h30;
      DW'(4):  s = 7'h19;
      DW'(5):  s = 7'h12;
      DW'(6):  s = 7'h02;
      DW'(7):  s = 7'h78;
      DW'(8):  s = 7'h00;
      DW'(9):  s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Refresh counter, digit index and the registered frame pulse.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= ONES;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (wrap) begin
        cnt <= '0;
        case (idx)
          ONES:    idx <= TENS;
          TENS:    idx <= HUNDREDS;
          default: idx <= ONES;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Digit snapshot; the display never looks at the live inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_h <= '0;
      snap_t <= '0;
      snap_o <= '0;
    end else if (score_load) begin
      snap_h <= hundreds;
      snap_t <= tens;
      snap_o <= ones;
    end
  end

  // Blink phase: counts frame ends while game over, idle-clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!game_over) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  logic [DW-1:0] cur_digit;
  logic          blanked;
  logic [2:0]    an_sel;

  // Output decode from registered state only: ghost guard, blink, blanking.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cur_digit = snap_o;
    blanked   = 1'b0;
    an_sel    = 3'b110;
    case (idx)
      TENS: begin
        cur_digit = snap_t;
        blanked   = (snap_h == '0) && (snap_t == '0);
        an_sel    = 3'b101;
      end
      HUNDREDS: begin
        cur_digit = snap_h;
        blanked   = (snap_h == '0);
        an_sel    = 3'b011;
      end
      default: ;
    endcase

    an  = AN_OFF;
    seg = SEG_OFF;
    if ((cnt != '0) && blink_on && !blanked) begin
      an  = an_sel;
      seg = seg_decode(cur_digit);
    end
  end

endmodule
